// File: rtl/matmul_arbiter.sv
// Round-robin arbiter sharing one 4x4 fixed-point matrix multiplier between NUM_REQ
// requesters. Operands and products pass through bit-exact; a watchdog aborts stuck operations.
module matmul_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                                           clk_in,
  input  logic                                           rst_n_in,
  input  logic        [NUM_REQ-1:0]                      req_in,
  input  logic signed [NUM_REQ-1:0][3:0][3:0][WIDTH-1:0] m1_in,
  input  logic signed [NUM_REQ-1:0][3:0][3:0][WIDTH-1:0] m2_in,
  output logic        [NUM_REQ-1:0]                      ack_out,
  output logic        [NUM_REQ-1:0]                      result_valid_out,
  output logic        [NUM_REQ-1:0]                      err_out,
  output logic signed [3:0][3:0][WIDTH-1:0]              result_out,
  output logic                                           busy_out,
  output logic                                           mm_start_out,
  output logic        [3:0][3:0][WIDTH-1:0]              mm_m1_out,
  output logic        [3:0][3:0][WIDTH-1:0]              mm_m2_out,
  input  logic                                           mm_busy_in,
  input  logic                                           mm_done_in,
  input  logic        [3:0][3:0][WIDTH-1:0]              mm_result_in
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_last;
  logic [IDX_W-1:0]   w_last_nxt;
  logic [IDX_W-1:0]   w_win;
  logic               w_found;
  logic [WD_W-1:0]    r_wdog;
  logic [WD_W-1:0]    w_wdog_nxt;
  logic [NUM_REQ-1:0] w_ack_nxt;
  logic [NUM_REQ-1:0] w_valid_nxt;
  logic [NUM_REQ-1:0] w_err_nxt;
  logic [NUM_REQ-1:0] w_win_oh;
  logic [NUM_REQ-1:0] w_gnt_oh;
  logic               w_start_nxt;
  logic               w_load_ops;
  logic               w_load_res;

  // Round-robin search: first asserted request after the last granted index.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!w_found && req_in[IDX_W'((32'(r_last) + k) % NUM_REQ)]) begin
        w_found = 1'b1;
        w_win   = IDX_W'((32'(r_last) + k) % NUM_REQ);
      end
    end
  end

  assign w_win_oh = NUM_REQ'(1) << w_win;
  assign w_gnt_oh = NUM_REQ'(1) << r_last;

  // Next state and next registered outputs; r_last doubles as the current grant in WAIT.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_wdog_nxt  = r_wdog;
    w_ack_nxt   = '0;
    w_valid_nxt = '0;
    w_err_nxt   = '0;
    w_start_nxt = 1'b0;
    w_load_ops  = 1'b0;
    w_load_res  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found && !mm_busy_in) begin
          w_state_nxt = ST_WAIT;
          w_last_nxt  = w_win;
          w_wdog_nxt  = '0;
          w_ack_nxt   = w_win_oh;
          w_start_nxt = 1'b1;
          w_load_ops  = 1'b1;
        end
      end
      ST_WAIT: begin
        if (mm_done_in) begin
          w_state_nxt = ST_IDLE;
          w_valid_nxt = w_gnt_oh;
          w_load_res  = 1'b1;
        end else if (r_wdog == WD_LAST) begin
          w_state_nxt = ST_IDLE;
          w_err_nxt   = w_gnt_oh;
        end else begin
          w_wdog_nxt = r_wdog + WD_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= ST_IDLE;
      r_last  <= LAST_RST;
      r_wdog  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_wdog  <= w_wdog_nxt;
    end
  end

  // Registered outputs and operand/result datapath.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ack_out          <= '0;
      result_valid_out <= '0;
      err_out          <= '0;
      result_out       <= '0;
      busy_out         <= 1'b0;
      mm_start_out     <= 1'b0;
      mm_m1_out        <= '0;
      mm_m2_out        <= '0;
    end else begin
      ack_out          <= w_ack_nxt;
      result_valid_out <= w_valid_nxt;
      err_out          <= w_err_nxt;
      busy_out         <= (w_state_nxt != ST_IDLE);
      mm_start_out     <= w_start_nxt;
      if (w_load_ops) begin
        mm_m1_out <= m1_in[w_win];
        mm_m2_out <= m2_in[w_win];
      end
      if (w_load_res) begin
        result_out <= mm_result_in;
      end
    end
  end

endmodule
